// File: rtl/gatebach_sieve_engine.sv
// rtl/gatebach_sieve_engine.sv - odd-number slice sieve with loadable prime table and word-serial bitmap output
module gatebach_sieve_engine #(
    parameter int SLICE_LENGTH = 2048,
    parameter int PRIME_NUM    = 32,
    parameter int PRIME_W      = 32,
    parameter int START_W      = 64,
    parameter int LANES        = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [START_W-1:0]                 start_addr,
    input  logic                               kick_start,
    input  logic                               auto_next,
    input  logic [$clog2(PRIME_NUM):0]         prime_num,
    input  logic                               cs_in,
    input  logic [$clog2(PRIME_NUM)-1:0]       add_in,
    input  logic [PRIME_W-1:0]                 data_in,
    output logic                               busy,
    output logic                               load_done,
    output logic                               proc_done,
    output logic                               store_done,
    output logic                               cs_out,
    output logic [$clog2(SLICE_LENGTH/32)-1:0] add_out,
    output logic [31:0]                        data_out,
    output logic [START_W-1:0]                 cur_addr
);

    localparam int WORDS = SLICE_LENGTH / 32;
    localparam int AW    = $clog2(PRIME_NUM);
    localparam int IW    = AW + 1;
    localparam int WW    = $clog2(WORDS);
    localparam int BW    = $clog2(SLICE_LENGTH);
    localparam int DW    = $clog2(START_W);
    // Offset must hold an in-slice index plus one full LANES*p stride.
    localparam int OW    = PRIME_W + 3;
    // Wide enough to compare p*p against base without losing either operand.
    localparam int CW    = ((2 * PRIME_W > START_W) ? 2 * PRIME_W : START_W) + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_INIT  = 3'd1;
    localparam logic [2:0] S_DIV   = 3'd2;
    localparam logic [2:0] S_CALC  = 3'd3;
    localparam logic [2:0] S_MARK  = 3'd4;
    localparam logic [2:0] S_NEXT  = 3'd5;
    localparam logic [2:0] S_STORE = 3'd6;

    logic [2:0]              state_q, state_d;
    logic [START_W-1:0]      base_q, base_d;
    logic                    had_slice_q, had_slice_d;
    logic                    load_done_q, load_done_d;
    logic                    proc_done_q, proc_done_d;
    logic                    store_done_q, store_done_d;
    logic [SLICE_LENGTH-1:0] bitmap_q, bitmap_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [DW-1:0]           div_cnt_q, div_cnt_d;
    logic [PRIME_W:0]        rem_q, rem_d;
    logic [OW-1:0]           off_q, off_d;
    logic [WW-1:0]           word_q, word_d;

    logic [PRIME_W-1:0]      prime_mem [PRIME_NUM];
    logic [PRIME_W-1:0]      prime_p;
    logic                    tbl_we;

    logic [PRIME_W:0]        rem_sh;
    logic [PRIME_W:0]        d_val;
    logic [2*PRIME_W-1:0]    pp;
    logic [CW-1:0]           calc_off;
    logic [OW-1:0]           pos;

    assign prime_p = prime_mem[idx_q[AW-1:0]];

    // Next-state logic: one prime at a time through DIV -> CALC -> MARK -> NEXT.
    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        had_slice_d  = had_slice_q;
        load_done_d  = load_done_q;
        proc_done_d  = proc_done_q;
        store_done_d = store_done_q;
        bitmap_d     = bitmap_q;
        idx_d        = idx_q;
        div_cnt_d    = div_cnt_q;
        rem_d        = rem_q;
        off_d        = off_q;
        word_d       = word_q;
        tbl_we       = 1'b0;
        rem_sh       = '0;
        d_val        = '0;
        pp           = '0;
        calc_off     = '0;
        pos          = '0;
        case (state_q)
            S_IDLE: begin
                tbl_we = cs_in;
                if (kick_start) begin
                    base_d       = (auto_next && had_slice_q)
                                 ? base_q + START_W'(2 * SLICE_LENGTH)
                                 : start_addr | START_W'(1);
                    load_done_d  = 1'b0;
                    proc_done_d  = 1'b0;
                    store_done_d = 1'b0;
                    state_d      = S_INIT;
                end
            end
            S_INIT: begin
                bitmap_d    = '1;
                load_done_d = 1'b1;
                idx_d       = '0;
                word_d      = '0;
                if (prime_num == '0) begin
                    proc_done_d = 1'b1;
                    state_d     = S_STORE;
                end else begin
                    div_cnt_d = DW'(START_W - 1);
                    rem_d     = '0;
                    state_d   = S_DIV;
                end
            end
            S_DIV: begin
                // Restoring remainder, one base bit per cycle, MSB first.
                rem_sh = {rem_q[PRIME_W-1:0], base_q[div_cnt_q]};
                if (rem_sh >= {1'b0, prime_p}) begin
                    rem_d = rem_sh - {1'b0, prime_p};
                end else begin
                    rem_d = rem_sh;
                end
                if (div_cnt_q == '0) begin
                    state_d = S_CALC;
                end else begin
                    div_cnt_d = div_cnt_q - DW'(1);
                end
            end
            S_CALC: begin
                // Distance to the first odd multiple at or after base, then halved to a bit index.
                d_val = (rem_q != '0) ? ({1'b0, prime_p} - rem_q) : '0;
                if (d_val[0]) begin
                    d_val = d_val + {1'b0, prime_p};
                end
                calc_off = CW'(d_val >> 1);
                pp = {{PRIME_W{1'b0}}, prime_p} * {{PRIME_W{1'b0}}, prime_p};
                // Start no lower than p*p so the prime itself survives.
                if (CW'(pp) > CW'(base_q)) begin
                    calc_off = (CW'(pp) - CW'(base_q)) >> 1;
                end
                if ((prime_p < PRIME_W'(3)) || (calc_off >= CW'(SLICE_LENGTH))) begin
                    state_d = S_NEXT;
                end else begin
                    off_d   = OW'(calc_off);
                    state_d = S_MARK;
                end
            end
            S_MARK: begin
                for (int k = 0; k < LANES; k++) begin
                    pos = off_q + OW'(k) * OW'(prime_p);
                    if (pos < OW'(SLICE_LENGTH)) begin
                        bitmap_d[pos[BW-1:0]] = 1'b0;
                    end
                end
                off_d = off_q + OW'(LANES) * OW'(prime_p);
                if (off_d >= OW'(SLICE_LENGTH)) begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                idx_d = idx_q + IW'(1);
                if (idx_d == prime_num) begin
                    proc_done_d = 1'b1;
                    word_d      = '0;
                    state_d     = S_STORE;
                end else begin
                    div_cnt_d = DW'(START_W - 1);
                    rem_d     = '0;
                    state_d   = S_DIV;
                end
            end
            S_STORE: begin
                if (word_q == WW'(WORDS - 1)) begin
                    store_done_d = 1'b1;
                    had_slice_d  = 1'b1;
                    state_d      = S_IDLE;
                end else begin
                    word_d = word_q + WW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            base_q       <= '0;
            had_slice_q  <= 1'b0;
            load_done_q  <= 1'b0;
            proc_done_q  <= 1'b0;
            store_done_q <= 1'b0;
            bitmap_q     <= '0;
            idx_q        <= '0;
            div_cnt_q    <= '0;
            rem_q        <= '0;
            off_q        <= '0;
            word_q       <= '0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            had_slice_q  <= had_slice_d;
            load_done_q  <= load_done_d;
            proc_done_q  <= proc_done_d;
            store_done_q <= store_done_d;
            bitmap_q     <= bitmap_d;
            idx_q        <= idx_d;
            div_cnt_q    <= div_cnt_d;
            rem_q        <= rem_d;
            off_q        <= off_d;
            word_q       <= word_d;
        end
    end

    // Prime table: no reset, written only while idle.
    always_ff @(posedge clk) begin
        if (tbl_we && !rst) begin
            prime_mem[add_in] <= data_in;
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign cs_out     = (state_q == S_STORE);
    assign add_out    = cs_out ? word_q : '0;
    assign data_out   = cs_out ? bitmap_q[{word_q, 5'd0} +: 32] : 32'd0;
    assign load_done  = load_done_q;
    assign proc_done  = proc_done_q;
    assign store_done = store_done_q;
    assign cur_addr   = base_q;

endmodule

// File: tb/tb_gatebach_sieve_engine.sv
// tb/tb_gatebach_sieve_engine.sv - randomized self-checking bench for gatebach_sieve_engine (LANES 1 and 4)
module tb_gatebach_sieve_engine;

    localparam int SL    = 2048;
    localparam int WORDS = SL / 32;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] start_addr;
    logic        kick_start;
    logic        auto_next;
    logic [5:0]  prime_num;
    logic        cs_in;
    logic [4:0]  add_in;
    logic [31:0] data_in;

    logic        busy1, load_done1, proc_done1, store_done1, cs1;
    logic [5:0]  add1;
    logic [31:0] data1;
    logic [63:0] cur1;
    logic        busy4, load_done4, proc_done4, store_done4, cs4;
    logic [5:0]  add4;
    logic [31:0] data4;
    logic [63:0] cur4;

    always #5 clk = ~clk;

    gatebach_sieve_engine #(.LANES(1)) dut1 (
        .clk(clk), .rst(rst), .start_addr(start_addr), .kick_start(kick_start),
        .auto_next(auto_next), .prime_num(prime_num), .cs_in(cs_in), .add_in(add_in),
        .data_in(data_in), .busy(busy1), .load_done(load_done1), .proc_done(proc_done1),
        .store_done(store_done1), .cs_out(cs1), .add_out(add1), .data_out(data1),
        .cur_addr(cur1)
    );

    gatebach_sieve_engine #(.LANES(4)) dut4 (
        .clk(clk), .rst(rst), .start_addr(start_addr), .kick_start(kick_start),
        .auto_next(auto_next), .prime_num(prime_num), .cs_in(cs_in), .add_in(add_in),
        .data_in(data_in), .busy(busy4), .load_done(load_done4), .proc_done(proc_done4),
        .store_done(store_done4), .cs_out(cs4), .add_out(add4), .data_out(data4),
        .cur_addr(cur4)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference model state
    logic [31:0]   tbl_m [32];
    int            np_m;
    logic [63:0]   cur_m;
    bit            had_m;
    logic [SL-1:0] exp_bm;
    int            exp_busy1, exp_busy4;

    logic [31:0]   got1 [WORDS];
    logic [31:0]   got4 [WORDS];
    int            busy_cnt1, busy_cnt4;

    // A number survives unless some table value p>=3 divides it and it is at least p*p.
    task automatic compute_model(input logic [63:0] base);
        longint unsigned p, n, ns;
        exp_bm    = '1;
        exp_busy1 = 1 + WORDS;
        exp_busy4 = 1 + WORDS;
        for (int j = 0; j < np_m; j++) begin
            p  = 64'(tbl_m[j]);
            ns = 0;
            if (p >= 3) begin
                for (int i = 0; i < SL; i++) begin
                    n = base + 64'(2 * i);
                    if ((n % p == 0) && (n >= p * p)) begin
                        exp_bm[i] = 1'b0;
                        ns++;
                    end
                end
            end
            exp_busy1 += 66 + int'(ns);
            exp_busy4 += 66 + int'((ns + 3) / 4);
        end
    endtask

    task automatic write_table();
        for (int i = 0; i < np_m; i++) begin
            @(negedge clk);
            cs_in   = 1'b1;
            add_in  = 5'(i);
            data_in = tbl_m[i];
        end
        @(negedge clk);
        cs_in     = 1'b0;
        prime_num = 6'(np_m);
    endtask

    task automatic run_job(input string tag, input logic [63:0] start, input bit auto, input bit inject);
        logic [63:0] base;
        bit done1, done4;
        int n1, n4, aerr1, aerr4;
        base = (auto && had_m) ? cur_m + 64'(2 * SL) : (start | 64'd1);
        compute_model(base);
        for (int w = 0; w < WORDS; w++) begin
            got1[w] = '0;
            got4[w] = '0;
        end
        busy_cnt1 = 0; busy_cnt4 = 0;
        done1 = 0; done4 = 0; n1 = 0; n4 = 0; aerr1 = 0; aerr4 = 0;
        @(negedge clk);
        start_addr = start;
        auto_next  = auto;
        kick_start = 1'b1;
        @(negedge clk);
        kick_start = 1'b0;
        for (int cyc = 0; cyc < 20000 && !(done1 && done4); cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (inject && cyc == 20) begin
                cs_in = 1'b1; add_in = 5'd0; data_in = 32'd11;
                kick_start = 1'b1; start_addr = 64'd999;
            end
            if (inject && cyc == 21) begin
                cs_in = 1'b0; kick_start = 1'b0; start_addr = start;
            end
            if (!done1) begin
                if (busy1) busy_cnt1++; else done1 = 1;
                if (cs1) begin
                    if (n1 < WORDS) got1[n1] = data1;
                    if (int'(add1) != n1) aerr1++;
                    n1++;
                end
            end
            if (!done4) begin
                if (busy4) busy_cnt4++; else done4 = 1;
                if (cs4) begin
                    if (n4 < WORDS) got4[n4] = data4;
                    if (int'(add4) != n4) aerr4++;
                    n4++;
                end
            end
        end
        check({tag, "_finished"}, 64'(done1 && done4), 64'd1);
        check({tag, "_busy_l1"}, 64'(busy_cnt1), 64'(exp_busy1));
        check({tag, "_busy_l4"}, 64'(busy_cnt4), 64'(exp_busy4));
        check({tag, "_nwords_l1"}, 64'(n1), 64'(WORDS));
        check({tag, "_nwords_l4"}, 64'(n4), 64'(WORDS));
        check({tag, "_addr_seq_l1"}, 64'(aerr1), 64'd0);
        check({tag, "_addr_seq_l4"}, 64'(aerr4), 64'd0);
        for (int w = 0; w < WORDS; w++) begin
            check($sformatf("%s_w%0d_l1", tag, w), 64'(got1[w]), 64'(exp_bm[32*w +: 32]));
            check($sformatf("%s_w%0d_l4", tag, w), 64'(got4[w]), 64'(exp_bm[32*w +: 32]));
        end
        check({tag, "_flags_l1"}, {60'd0, load_done1, proc_done1, store_done1, cs1}, 64'hE);
        check({tag, "_flags_l4"}, {60'd0, load_done4, proc_done4, store_done4, cs4}, 64'hE);
        check({tag, "_cur_l1"}, cur1, base);
        check({tag, "_cur_l4"}, cur4, base);
        cur_m = base;
        had_m = 1;
    endtask

    logic        all_ones;
    int          sel;
    logic [63:0] rstart;

    initial begin
        rst = 1'b1; start_addr = '0; kick_start = 1'b0; auto_next = 1'b0;
        prime_num = '0; cs_in = 1'b0; add_in = '0; data_in = '0;
        cur_m = '0; had_m = 0; np_m = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 64'(busy1), 64'd0);
        check("rst_flags", {61'd0, load_done1, proc_done1, store_done1}, 64'd0);
        check("rst_cs_out", 64'(cs1), 64'd0);
        check("rst_add_out", 64'(add1), 64'd0);
        check("rst_data_out", 64'(data1), 64'd0);
        check("rst_cur_addr", cur1, 64'd0);
        check("rst_busy_l4", 64'(busy4), 64'd0);

        // Single prime 5 on slice starting at 201
        tbl_m[0] = 32'd5; np_m = 1;
        write_table();
        run_job("t1", 64'hC9, 0, 0);
        check("t1_bit2_205", 64'(got1[0][2]), 64'd0);
        check("t1_bit7_215", 64'(got1[0][7]), 64'd0);
        check("t1_bit0_201", 64'(got1[0][0]), 64'd1);
        check("t1_busy_exact", 64'(busy_cnt1), 64'd541);

        // Primes 3,5,7 from 1, with table write and kick attempted while busy
        tbl_m[0] = 32'd3; tbl_m[1] = 32'd5; tbl_m[2] = 32'd7; np_m = 3;
        write_table();
        run_job("t2", 64'd1, 0, 1);
        foreach (got1[0][b]) begin
            if (b inside {4, 7, 10, 12, 13, 16, 17, 22, 24})
                check($sformatf("t2_bit%0d_struck", b), 64'(got1[0][b]), 64'd0);
            if (b inside {0, 1, 2, 3})
                check($sformatf("t2_bit%0d_kept", b), 64'(got1[0][b]), 64'd1);
        end
        check("t3_lanes4_fewer_cycles", 64'(busy_cnt4 < busy_cnt1), 64'd1);
        run_job("t2b_table_intact", 64'd1, 0, 0);

        // Degenerate table: no strikes at all
        tbl_m[0] = 32'd2; tbl_m[1] = 32'd0; tbl_m[2] = 32'd65537; np_m = 3;
        write_table();
        run_job("t5", 64'hC9, 0, 0);
        all_ones = 1'b1;
        for (int w = 0; w < WORDS; w++) all_ones &= (got1[w] == 32'hFFFF_FFFF);
        check("t5_all_ones", 64'(all_ones), 64'd1);
        check("t5_busy_exact", 64'(busy_cnt1), 64'd263);

        // Reset while marking
        tbl_m[0] = 32'd3; np_m = 1;
        write_table();
        @(negedge clk);
        start_addr = 64'd1; auto_next = 1'b0; kick_start = 1'b1;
        @(negedge clk);
        kick_start = 1'b0;
        repeat (100) @(negedge clk);
        check("t6_mid_load_done", 64'(load_done1), 64'd1);
        check("t6_mid_proc_done", 64'(proc_done1), 64'd0);
        check("t6_mid_busy", 64'(busy1 & busy4), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_busy", 64'(busy1 | busy4), 64'd0);
        check("t6_rst_flags", {61'd0, load_done1, proc_done1, store_done1}, 64'd0);
        check("t6_rst_cs_out", 64'(cs1 | cs4), 64'd0);
        check("t6_rst_cur", cur1, 64'd0);
        rst = 1'b0;
        had_m = 0; cur_m = '0;

        // Auto-advance across two slices
        tbl_m[0] = 32'd3; tbl_m[1] = 32'd5; tbl_m[2] = 32'd7; np_m = 3;
        write_table();
        run_job("t4a", 64'd201, 1, 0);
        check("t4a_cur_201", cur1, 64'd201);
        run_job("t4b", 64'd201, 1, 0);
        check("t4b_cur_4297", cur1, 64'd4297);
        check("t4b_4297_prime", 64'(got1[0][0]), 64'd1);

        // Empty table
        np_m = 0;
        write_table();
        run_job("t0_empty", 64'd77, 0, 0);
        check("t0_busy_exact", 64'(busy_cnt1), 64'd65);

        // Randomized jobs
        for (int r = 0; r < 8; r++) begin
            np_m = int'($urandom_range(0, 6));
            for (int j = 0; j < np_m; j++) begin
                sel = int'($urandom_range(0, 9));
                if (sel == 0)      tbl_m[j] = 32'($urandom_range(0, 2));
                else if (sel == 1) tbl_m[j] = 32'd65537;
                else               tbl_m[j] = 32'($urandom_range(1, 127) * 2 + 1);
            end
            write_table();
            rstart = {$urandom, $urandom} & 64'hFF_FFFF_FFFF;
            run_job($sformatf("rnd%0d", r), rstart, bit'($urandom_range(0, 1)), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
